// File: rtl/sap1_uart_loader.sv
// Serial program loader for sap1: receives an 8N1 UART image (sync, 16 words, checksum),
// writes it through the front-panel port, then requests a CPU clear.
module sap1_uart_loader #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          NUM_WORDS    = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       rx,
   input  logic       clken,
   input  logic       clken_oop,
   output logic       fp_prog,
   output logic       fp_write,
   output logic [3:0] fp_adr,
   output logic [7:0] fp_data,
   output logic       fp_clear,
   output logic       busy,
   output logic       done,
   output logic [1:0] err
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST    = 4'(NUM_WORDS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_CLEAR, S_ERR} st_e;

   rx_st_e        rx_st_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic          byte_vld_q, byte_ferr_q;

   st_e           st_q;
   logic [7:0]    sum_q, sum_d, chk_exp;
   logic [3:0]    adr_q, adr_d;
   logic [7:0]    data_q;
   logic          prog_q, write_q, clear_q, busy_q, done_q;
   logic [1:0]    err_q;
   logic          sync_hit;

   // Receiver: edge-triggered start, mid-bit sampling, byte flagged one cycle after stop sample.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_st_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         byte_vld_q  <= 1'b0;
         byte_ferr_q <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         byte_vld_q <= 1'b0;
         cnt_q      <= cnt_q + 1'b1;
         case (rx_st_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_st_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  rx_st_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) rx_st_q <= RX_STOP;
               end
            end
            default: begin
               if (cnt_q == FULL_M1) begin
                  byte_vld_q  <= 1'b1;
                  byte_ferr_q <= !rx_s2_q;
                  rx_st_q     <= RX_IDLE;
               end
            end
         endcase
      end
   end

   assign sum_d    = sum_q + shift_q;
   assign chk_exp  = ~sum_q + 8'd1;
   assign adr_d    = adr_q + 4'd1;
   assign sync_hit = byte_vld_q && !byte_ferr_q && (shift_q == SYNC_BYTE);

   always_ff @(posedge sysclk) begin
      if (reset) begin
         st_q    <= S_IDLE;
         sum_q   <= '0;
         adr_q   <= '0;
         data_q  <= '0;
         prog_q  <= 1'b0;
         write_q <= 1'b0;
         clear_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 2'b00;
      end else begin
         done_q <= 1'b0;
         case (st_q)
            S_IDLE, S_ERR: begin
               if (sync_hit) begin
                  st_q   <= S_LOAD;
                  prog_q <= 1'b1;
                  busy_q <= 1'b1;
                  adr_q  <= '0;
                  sum_q  <= '0;
                  err_q  <= 2'b00;
               end
            end
            S_LOAD: begin
               if (byte_vld_q) begin
                  if (byte_ferr_q) begin
                     st_q   <= S_ERR;
                     prog_q <= 1'b0;
                     busy_q <= 1'b0;
                     err_q  <= 2'b01;
                  end else begin
                     st_q    <= S_WRITE;
                     data_q  <= shift_q;
                     sum_q   <= sum_d;
                     write_q <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               // A byte landing before the memory strobe would be lost: abort the frame.
               if (byte_vld_q) begin
                  st_q    <= S_ERR;
                  prog_q  <= 1'b0;
                  write_q <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 2'b11;
               end else if (clken_oop) begin
                  write_q <= 1'b0;
                  adr_q   <= adr_d;
                  st_q    <= (adr_q == LAST) ? S_CHECK : S_LOAD;
               end
            end
            S_CHECK: begin
               if (byte_vld_q) begin
                  if (!byte_ferr_q && shift_q == chk_exp) begin
                     st_q    <= S_CLEAR;
                     prog_q  <= 1'b0;
                     clear_q <= 1'b1;
                  end else begin
                     st_q   <= S_ERR;
                     prog_q <= 1'b0;
                     busy_q <= 1'b0;
                     err_q  <= byte_ferr_q ? 2'b01 : 2'b10;
                  end
               end
            end
            S_CLEAR: begin
               if (clken) begin
                  clear_q <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  st_q    <= S_IDLE;
               end
            end
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign fp_prog  = prog_q;
   assign fp_write = write_q;
   assign fp_adr   = adr_q;
   assign fp_data  = data_q;
   assign fp_clear = clear_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_sap1_uart_loader.sv
// Bench for sap1_uart_loader: UART frames driven bit by bit, memory writes checked
// against a queue of expected {adr,data} pushed as each byte is sent.
module tb_sap1_uart_loader;
   localparam int CPB = 16;

   logic       sysclk = 1'b0, reset = 1'b1, rx = 1'b1, clken = 1'b0, clken_oop = 1'b0;
   logic       fp_prog, fp_write, fp_clear, busy, done;
   logic [3:0] fp_adr;
   logic [7:0] fp_data;
   logic [1:0] err;

   int          n_cmp = 0, n_bad = 0, done_cnt = 0;
   bit          oop_en = 1'b1;
   logic        prev_clear = 1'b0;
   logic [11:0] exp_q[$];
   logic [11:0] exp_w;

   sap1_uart_loader #(.CLKS_PER_BIT(CPB), .NUM_WORDS(16), .SYNC_BYTE(8'hA5)) dut (
      .sysclk(sysclk), .reset(reset), .rx(rx), .clken(clken), .clken_oop(clken_oop),
      .fp_prog(fp_prog), .fp_write(fp_write), .fp_adr(fp_adr), .fp_data(fp_data),
      .fp_clear(fp_clear), .busy(busy), .done(done), .err(err)
   );

   always #5 sysclk = ~sysclk;

   // CPU-side strobes: memory strobe every 4th cycle (gateable), register strobe every 5th.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge sysclk); #1;
         ph++;
         clken_oop = oop_en && (ph % 4 == 0);
         clken     = (ph % 5 == 0);
      end
   end

   always @(negedge sysclk) begin
      if (!reset) begin
         if (fp_write && clken_oop) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL write_unexpected: got adr=%0d data=%h, none expected", fp_adr, fp_data);
            end else begin
               exp_w = exp_q.pop_front();
               if ({fp_adr, fp_data} !== exp_w || fp_prog !== 1'b1) begin
                  n_bad++;
                  $display("FAIL write: got adr=%0d data=%h prog=%b, want adr=%0d data=%h prog=1",
                           fp_adr, fp_data, fp_prog, exp_w[11:8], exp_w[7:0]);
               end
            end
         end
         if (done) begin
            n_cmp++;
            done_cnt++;
            if (prev_clear !== 1'b1 || fp_clear !== 1'b0) begin
               n_bad++;
               $display("FAIL done_order: prev fp_clear=%b now fp_clear=%b, want 1 then 0", prev_clear, fp_clear);
            end
         end
         prev_clear = fp_clear;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0; cyc(CPB);
      for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(CPB); end
      rx = stop; cyc(CPB);
      rx = 1'b1; cyc(CPB);
   endtask

   // Sync + n_data words (d0, d0+1, ...); word bad_at gets a 0 stop bit; checksum sent only for full frames.
   task automatic send_frame(input logic [7:0] d0, input int n_data, input int bad_at, input bit bad_chk);
      logic [7:0] sum, b;
      sum = 8'h00;
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < n_data; i++) begin
         b = d0 + 8'(i);
         sum = sum + b;
         if (i != bad_at) exp_q.push_back({4'(i), b});
         send_byte(b, i != bad_at);
      end
      if (n_data == 16) send_byte(bad_chk ? 8'h00 : 8'h00 - sum, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1; cyc(3);
      n_cmp++;
      if ({fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, err} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h, want 0",
                  {fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, err});
      end
      reset = 1'b0; cyc(2);
   endtask

   task automatic test_frame_ok(input logic [7:0] d0, input string nm);
      int d;
      d = done_cnt;
      send_frame(d0, 16, -1, 1'b0);
      cyc(20);
      n_cmp++;
      if (done_cnt !== d + 1 || err !== 2'b00 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: done=%0d err=%b pending=%0d, want done=%0d err=00 pending=0",
                  nm, done_cnt - d, err, exp_q.size(), 1);
      end
      n_cmp++;
      if (fp_adr !== 4'd0 || fp_prog !== 1'b0 || busy !== 1'b0 || fp_clear !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_idle: adr=%0d prog=%b busy=%b clear=%b, want 0 0 0 0",
                  nm, fp_adr, fp_prog, busy, fp_clear);
      end
   endtask

   task automatic test_glitch();
      rx = 1'b0; cyc(CPB / 2 - 2);
      rx = 1'b1; cyc(2 * CPB);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
      send_byte(8'h3C, 1'b1);
      n_cmp++;
      if (busy !== 1'b0 || fp_prog !== 1'b0) begin
         n_bad++; $display("FAIL noise_byte: busy=%b prog=%b, want 0 0", busy, fp_prog);
      end
      test_frame_ok(8'h01, "glitch_then_frame");
   endtask

   task automatic test_bad_checksum();
      int d;
      d = done_cnt;
      send_frame(8'h01, 16, -1, 1'b1);
      cyc(20);
      n_cmp++;
      if (err !== 2'b10 || fp_prog !== 1'b0 || fp_clear !== 1'b0 || done_cnt !== d || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL checksum: err=%b prog=%b clear=%b dones=%0d pending=%0d, want 10 0 0 0 0",
                  err, fp_prog, fp_clear, done_cnt - d, exp_q.size());
      end
   endtask

   task automatic test_framing();
      send_frame(8'h01, 3, 2, 1'b0);
      cyc(8);
      n_cmp++;
      if (err !== 2'b01 || fp_prog !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL framing: err=%b prog=%b busy=%b pending=%0d, want 01 0 0 0",
                  err, fp_prog, busy, exp_q.size());
      end
      test_frame_ok(8'h20, "framing_recover");
   endtask

   task automatic test_overrun();
      oop_en = 1'b0;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b1);
      n_cmp++;
      if (fp_write !== 1'b1 || fp_data !== 8'h11) begin
         n_bad++; $display("FAIL overrun_stall: write=%b data=%h, want 1 11", fp_write, fp_data);
      end
      send_byte(8'h22, 1'b1);
      cyc(4);
      n_cmp++;
      if (err !== 2'b11 || fp_write !== 1'b0 || fp_prog !== 1'b0) begin
         n_bad++; $display("FAIL overrun: err=%b write=%b prog=%b, want 11 0 0", err, fp_write, fp_prog);
      end
      oop_en = 1'b1;
      cyc(4);
   endtask

   task automatic test_reset_mid();
      send_frame(8'h40, 7, -1, 1'b0);
      oop_en = 1'b0;
      cyc(2);
      send_byte(8'h47, 1'b1);
      for (int i = 0; i < 50 && fp_write !== 1'b1; i++) cyc(1);
      n_cmp++;
      if (fp_write !== 1'b1 || fp_adr !== 4'd7 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL mid_write: write=%b adr=%0d pending=%0d, want 1 7 0", fp_write, fp_adr, exp_q.size());
      end
      reset = 1'b1; cyc(1);
      n_cmp++;
      if ({fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, err} !== 19'd0) begin
         n_bad++;
         $display("FAIL mid_reset: got %h, want 0",
                  {fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, err});
      end
      reset = 1'b0;
      oop_en = 1'b1;
      cyc(4);
      test_frame_ok(8'h50, "after_reset");
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_frame_ok(8'h01, "load");
      test_frame_ok(8'h9A, "back_to_back");
      test_bad_checksum();
      test_framing();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
